// File: rtl/text_grid_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : text_grid_write_arbiter
//  Brief    : Round-robin write arbiter, clear sequencer and read-address mux
//             for the character-grid dmem. Optional macro: CURSOR_TRACK_EN.
//  Revision : 1.0  initial release
// ============================================================================
module text_grid_write_arbiter #(
    parameter int         COLS     = 40,
    parameter int         ROWS     = 30,
    parameter logic [7:0] CLR_CHAR = 8'h20
) (
    input  logic        FPGA_clock,
    input  logic        iRST_n,
    input  logic [1:0]  req,
    input  logic [5:0]  req_x0,
    input  logic [5:0]  req_y0,
    input  logic [7:0]  req_d0,
    input  logic [5:0]  req_x1,
    input  logic [5:0]  req_y1,
    input  logic [7:0]  req_d1,
    output logic [1:0]  ack,
    output logic        err_oob,
    input  logic        clr_start,
    output logic        busy,
    output logic        clr_done,
    input  logic [5:0]  rd_x,
    input  logic [5:0]  rd_y,
    output logic [10:0] dmem_addr,
    output logic [7:0]  dmem_data,
    output logic        dmem_wren,
    output logic [5:0]  cursor_x,
    output logic [5:0]  cursor_y
);

    localparam logic [10:0] c_COLS = 11'(COLS);
    localparam logic [10:0] c_LAST = 11'(COLS * ROWS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_CLEAR = 2'd2
    } state_t;

    state_t      r_state;
    logic [1:0]  r_ack;
    logic        r_err_oob;
    logic        r_clr_done;
    logic        r_wren;
    logic [7:0]  r_data;
    logic [10:0] r_addr;
    logic [10:0] r_clr_cnt;
    logic        r_favour;      // requester that wins the next contention

    logic        w_gnt1;
    logic [5:0]  w_x;
    logic [5:0]  w_y;
    logic [7:0]  w_d;
    logic        w_in_grid;
    logic [10:0] w_wr_addr;
    logic [10:0] w_rd_addr;

    always_comb begin
        w_gnt1    = req[1] & (~req[0] | r_favour);
        w_x       = w_gnt1 ? req_x1 : req_x0;
        w_y       = w_gnt1 ? req_y1 : req_y0;
        w_d       = w_gnt1 ? req_d1 : req_d0;
        w_in_grid = (32'(w_x) < COLS) && (32'(w_y) < ROWS);
        w_wr_addr = 11'(w_y) * c_COLS + 11'(w_x);
        w_rd_addr = 11'(rd_y) * c_COLS + 11'(rd_x);
    end

`ifdef CURSOR_TRACK_EN
    logic [5:0] r_cursor_x;
    logic [5:0] r_cursor_y;
    logic [5:0] w_cur_x_nxt;
    logic [5:0] w_cur_y_nxt;
    logic       w_x_last;
    logic       w_y_last;

    // Cursor advances left-to-right, wraps to the next row, then to the top.
    always_comb begin
        w_x_last    = (32'(w_x) == COLS - 1);
        w_y_last    = (32'(w_y) == ROWS - 1);
        w_cur_x_nxt = w_x_last ? 6'd0 : w_x + 6'd1;
        w_cur_y_nxt = w_x_last ? (w_y_last ? 6'd0 : w_y + 6'd1) : w_y;
    end

    assign cursor_x = r_cursor_x;
    assign cursor_y = r_cursor_y;
`else
    assign cursor_x = 6'd0;
    assign cursor_y = 6'd0;
`endif

    always_ff @(posedge FPGA_clock) begin
        if (!iRST_n) begin
            r_state    <= S_IDLE;
            r_ack      <= 2'b00;
            r_err_oob  <= 1'b0;
            r_clr_done <= 1'b0;
            r_wren     <= 1'b0;
            r_data     <= 8'h00;
            r_addr     <= 11'd0;
            r_clr_cnt  <= 11'd0;
            r_favour   <= 1'b0;
`ifdef CURSOR_TRACK_EN
            r_cursor_x <= 6'd0;
            r_cursor_y <= 6'd0;
`endif
        end else begin
            r_ack      <= 2'b00;
            r_err_oob  <= 1'b0;
            r_clr_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (clr_start) begin
                        r_state   <= S_CLEAR;
                        r_clr_cnt <= 11'd0;
                        r_addr    <= 11'd0;
                        r_wren    <= 1'b1;
                        r_data    <= CLR_CHAR;
                    end else if (|req) begin
                        r_state   <= S_WRITE;
                        r_ack     <= w_gnt1 ? 2'b10 : 2'b01;
                        r_wren    <= w_in_grid;
                        r_err_oob <= ~w_in_grid;
                        r_addr    <= w_wr_addr;
                        r_data    <= w_d;
                        r_favour  <= ~w_gnt1;
`ifdef CURSOR_TRACK_EN
                        if (w_in_grid) begin
                            r_cursor_x <= w_cur_x_nxt;
                            r_cursor_y <= w_cur_y_nxt;
                        end
`endif
                    end else begin
                        r_wren <= 1'b0;
                    end
                end
                S_WRITE: begin
                    r_state <= S_IDLE;
                    r_wren  <= 1'b0;
                end
                S_CLEAR: begin
                    if (r_clr_cnt == c_LAST) begin
                        r_state    <= S_IDLE;
                        r_wren     <= 1'b0;
                        r_clr_done <= 1'b1;
                        r_clr_cnt  <= 11'd0;
`ifdef CURSOR_TRACK_EN
                        r_cursor_x <= 6'd0;
                        r_cursor_y <= 6'd0;
`endif
                    end else begin
                        r_clr_cnt <= r_clr_cnt + 11'd1;
                        r_addr    <= r_clr_cnt + 11'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_wren  <= 1'b0;
                end
            endcase
        end
    end

    // Display reads own the address bus whenever no write is in flight.
    assign dmem_addr = (r_state == S_IDLE) ? w_rd_addr : r_addr;
    assign dmem_data = r_data;
    assign dmem_wren = r_wren;
    assign ack       = r_ack;
    assign err_oob   = r_err_oob;
    assign clr_done  = r_clr_done;
    assign busy      = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_text_grid_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_text_grid_write_arbiter
//  Brief    : Directed vector bench for text_grid_write_arbiter.
//  Revision : 1.0  initial release
// ============================================================================
module tb_text_grid_write_arbiter;

    logic        FPGA_clock = 1'b0;
    logic        iRST_n     = 1'b0;
    logic [1:0]  req        = 2'b00;
    logic [5:0]  req_x0 = 6'd0, req_y0 = 6'd0, req_x1 = 6'd0, req_y1 = 6'd0;
    logic [7:0]  req_d0 = 8'h00, req_d1 = 8'h00;
    logic        clr_start  = 1'b0;
    logic [5:0]  rd_x = 6'd0, rd_y = 6'd0;
    logic [1:0]  ack;
    logic        err_oob, busy, clr_done, dmem_wren;
    logic [10:0] dmem_addr;
    logic [7:0]  dmem_data;
    logic [5:0]  cursor_x, cursor_y;

    int n_checks = 0;
    int n_errors = 0;
    int m_cx = 0;
    int m_cy = 0;

    text_grid_write_arbiter dut (
        .FPGA_clock(FPGA_clock), .iRST_n(iRST_n), .req(req),
        .req_x0(req_x0), .req_y0(req_y0), .req_d0(req_d0),
        .req_x1(req_x1), .req_y1(req_y1), .req_d1(req_d1),
        .ack(ack), .err_oob(err_oob), .clr_start(clr_start), .busy(busy),
        .clr_done(clr_done), .rd_x(rd_x), .rd_y(rd_y), .dmem_addr(dmem_addr),
        .dmem_data(dmem_data), .dmem_wren(dmem_wren),
        .cursor_x(cursor_x), .cursor_y(cursor_y)
    );

    always #5 FPGA_clock = ~FPGA_clock;

    typedef struct {
        logic [1:0]  req;
        logic [5:0]  x0, y0;
        logic [7:0]  d0;
        logic [5:0]  x1, y1;
        logic [7:0]  d1;
        logic [1:0]  ack;
        logic        err;
        logic        wren;
        logic [10:0] addr;
        logic [7:0]  data;
    } vec_t;

    vec_t vecs[8];

    task automatic tick();
        @(posedge FPGA_clock);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Reference cursor behaviour for an accepted write at (x,y).
    task automatic model_write(input int x, input int y);
        if (x < 40 && y < 30) begin
            if (x + 1 == 40) begin
                m_cx = 0;
                m_cy = (y + 1 == 30) ? 0 : y + 1;
            end else begin
                m_cx = x + 1;
                m_cy = y;
            end
        end
    endtask

    task automatic check_cursor(input string name);
`ifdef CURSOR_TRACK_EN
        check({name, "_cx"}, 32'(cursor_x), 32'(m_cx));
        check({name, "_cy"}, 32'(cursor_y), 32'(m_cy));
`else
        check({name, "_cx"}, 32'(cursor_x), 32'd0);
        check({name, "_cy"}, 32'(cursor_y), 32'd0);
`endif
    endtask

    task automatic do_reset();
        iRST_n = 1'b0;
        tick();
        tick();
        iRST_n = 1'b1;
        m_cx = 0;
        m_cy = 0;
    endtask

    initial begin
        //             req    x0     y0     d0     x1     y1     d1     ack    err  wren addr      data
        vecs[0] = '{2'b01, 6'd3,  6'd2,  8'h41, 6'd0,  6'd0,  8'h00, 2'b01, 1'b0, 1'b1, 11'd83,   8'h41};
        vecs[1] = '{2'b10, 6'd0,  6'd0,  8'h00, 6'd40, 6'd0,  8'h42, 2'b10, 1'b1, 1'b0, 11'd40,   8'h42};
        vecs[2] = '{2'b11, 6'd0,  6'd0,  8'h61, 6'd5,  6'd1,  8'h62, 2'b01, 1'b0, 1'b1, 11'd0,    8'h61};
        vecs[3] = '{2'b11, 6'd0,  6'd0,  8'h61, 6'd5,  6'd1,  8'h62, 2'b10, 1'b0, 1'b1, 11'd45,   8'h62};
        vecs[4] = '{2'b10, 6'd0,  6'd0,  8'h00, 6'd39, 6'd29, 8'h7E, 2'b10, 1'b0, 1'b1, 11'd1199, 8'h7E};
        vecs[5] = '{2'b01, 6'd0,  6'd30, 8'h55, 6'd0,  6'd0,  8'h00, 2'b01, 1'b1, 1'b0, 11'd1200, 8'h55};
        vecs[6] = '{2'b11, 6'd63, 6'd63, 8'h01, 6'd10, 6'd10, 8'h02, 2'b10, 1'b0, 1'b1, 11'd410,  8'h02};
        vecs[7] = '{2'b01, 6'd39, 6'd5,  8'h33, 6'd0,  6'd0,  8'h00, 2'b01, 1'b0, 1'b1, 11'd239,  8'h33};

        // Reset state, with the display read address on the bus.
        do_reset();
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_err", 32'(err_oob), 32'd0);
        check("rst_done", 32'(clr_done), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_wren", 32'(dmem_wren), 32'd0);
        check("rst_data", 32'(dmem_data), 32'd0);
        check_cursor("rst");
        rd_x = 6'd7;
        rd_y = 6'd3;
        #1;
        check("rd_addr", 32'(dmem_addr), 32'd127);

        // Both requesters held high: grants alternate starting with requester 0.
        req_x0 = 6'd1; req_y0 = 6'd1; req_d0 = 8'h11;
        req_x1 = 6'd2; req_y1 = 6'd1; req_d1 = 8'h22;
        req = 2'b11;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("hold_ack", 32'(ack), (k % 2 == 0) ? 32'd1 : 32'd2);
            check("hold_data", 32'(dmem_data), (k % 2 == 0) ? 32'h11 : 32'h22);
            check("hold_wren", 32'(dmem_wren), 32'd1);
            if (k % 2 == 0) model_write(1, 1);
            else            model_write(2, 1);
            tick();
            check("hold_gap_ack", 32'(ack), 32'd0);
        end
        req = 2'b00;
        check_cursor("hold");

        // Single-write vectors.
        for (int i = 0; i < 8; i++) begin
            req = vecs[i].req;
            req_x0 = vecs[i].x0; req_y0 = vecs[i].y0; req_d0 = vecs[i].d0;
            req_x1 = vecs[i].x1; req_y1 = vecs[i].y1; req_d1 = vecs[i].d1;
            tick();
            check("vec_ack", 32'(ack), 32'(vecs[i].ack));
            check("vec_err", 32'(err_oob), 32'(vecs[i].err));
            check("vec_wren", 32'(dmem_wren), 32'(vecs[i].wren));
            check("vec_addr", 32'(dmem_addr), 32'(vecs[i].addr));
            check("vec_data", 32'(dmem_data), 32'(vecs[i].data));
            check("vec_busy", 32'(busy), 32'd1);
            if (vecs[i].ack == 2'b10) model_write(int'(vecs[i].x1), int'(vecs[i].y1));
            else                      model_write(int'(vecs[i].x0), int'(vecs[i].y0));
            req = 2'b00;
            tick();
            check("vec_idle_ack", 32'(ack), 32'd0);
            check("vec_idle_err", 32'(err_oob), 32'd0);
            check("vec_idle_wren", 32'(dmem_wren), 32'd0);
            check("vec_idle_busy", 32'(busy), 32'd0);
            check_cursor("vec");
        end

        // Full clear; clr_start beats a simultaneous request, which waits.
        req_x0 = 6'd1; req_y0 = 6'd0; req_d0 = 8'hAA;
        req = 2'b01;
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        for (int i = 0; i < 1200; i++) begin
            check("clr_wren", 32'(dmem_wren), 32'd1);
            check("clr_addr", 32'(dmem_addr), 32'(i));
            check("clr_data", 32'(dmem_data), 32'h20);
            check("clr_busy", 32'(busy), 32'd1);
            check("clr_ack", 32'(ack), 32'd0);
            check("clr_done_early", 32'(clr_done), 32'd0);
            if (i == 600) clr_start = 1'b1;
            if (i == 601) clr_start = 1'b0;
            tick();
        end
        check("clr_done", 32'(clr_done), 32'd1);
        check("clr_done_wren", 32'(dmem_wren), 32'd0);
        check("clr_done_busy", 32'(busy), 32'd0);
        check("clr_done_ack", 32'(ack), 32'd0);
        m_cx = 0;
        m_cy = 0;
        check_cursor("clr");
        tick();
        check("post_clr_ack", 32'(ack), 32'd1);
        check("post_clr_addr", 32'(dmem_addr), 32'd1);
        check("post_clr_data", 32'(dmem_data), 32'hAA);
        check("post_clr_done", 32'(clr_done), 32'd0);
        model_write(1, 0);
        req = 2'b00;
        tick();

        // Reset in the middle of a sweep, then restart from address 0.
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        for (int i = 0; i < 500; i++) tick();
        check("mid_addr", 32'(dmem_addr), 32'd500);
        iRST_n = 1'b0;
        tick();
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_wren", 32'(dmem_wren), 32'd0);
        check("abort_done", 32'(clr_done), 32'd0);
        iRST_n = 1'b1;
        m_cx = 0;
        m_cy = 0;
        tick();
        check("abort_no_done", 32'(clr_done), 32'd0);
        check_cursor("abort");
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        check("restart_addr", 32'(dmem_addr), 32'd0);
        check("restart_wren", 32'(dmem_wren), 32'd1);
        tick();
        check("restart_addr1", 32'(dmem_addr), 32'd1);
        do_reset();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
